alu_issue_ctrl: RTL and testbench
=================================

# alu_issue_ctrl

Multi-cycle issue and writeback sequencer that drives the datapath ALU. It accepts one MIPS R/I-type arithmetic, logic or shift instruction with its register operands over a valid/ready handshake. It decodes the instruction into the 4-bit ALU operation code and operand pair, then captures the ALU result into the Z register and the flags into the flag register. It presents a register-file writeback over a second valid/ready handshake. It sits between the register-read stage and the register-file write port.

## Interface
Parameters:
- `DATA_W`, 32, datapath width; only 32 is supported.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  instruction and operands valid.
- `in_ready`  out  1  block can accept an instruction.
- `instr`  in  32  MIPS instruction word.
- `rs_data`  in  32  rs register value.
- `rt_data`  in  32  rt register value.
- `alu_a`  out  32  ALU operand A.
- `alu_b`  out  32  ALU operand B.
- `alu_op`  out  4  ALU operation code.
- `alu_result`  in  32  combinational ALU result.
- `alu_zero`  in  1  ALU zero flag.
- `alu_carry`  in  1  ALU carry flag.
- `alu_negative`  in  1  ALU negative flag.
- `wb_valid`  out  1  writeback valid.
- `wb_ready`  in  1  register file accepts the writeback.
- `wb_rd`  out  5  destination register.
- `wb_data`  out  32  Z register contents.
- `wb_we`  out  1  write enable qualifying `wb_data`.
- `illegal`  out  1  held instruction was not decodable; valid while `wb_valid`=1.
- `flag_z`, `flag_c`, `flag_n`  out  1 each  flag register.

## Operation
FSM states and transitions:
- IDLE: `in_ready`=1. On `in_valid` with `in_ready` high, latch `instr`, `rs_data` and `rt_data`, then go to DECODE.
- DECODE: register `alu_op`, `alu_a`, `alu_b`, `wb_rd` and the illegal bit. A legal instruction goes to EXEC. An illegal one goes to WB.
- EXEC: the ALU settles combinationally from the registered operands. At the end of the cycle, capture `alu_result` into Z and the three flags into the flag register. Go to WB.
- WB: `wb_valid`=1. Hold `wb_rd`, `wb_data`, `wb_we` and `illegal` stable until `wb_ready`. On `wb_valid` and `wb_ready` both high, go to IDLE.

Decode rules (opcode 0 means R-type, selected by funct):
- add 0x20→0010, addu 0x21→0000, sub 0x22→0011, subu 0x23→0001.
- and 0x24→0100, or 0x25→0101, xor 0x26→0110, nor 0x27→0111.
- slt 0x2A→1011, sltu 0x2B→1010.
- For all of the above: A=rs, B=rt, rd=instr[15:11].
- Shifts: sll 0x00→1110, srl 0x02→1101, sra 0x03→1100. A=zero-extended shamt instr[10:6], B=rt, rd=instr[15:11].
- I-type: addi 0x08→0010, addiu 0x09→0000, slti 0x0A→1011, sltiu 0x0B→1010, all with sign-extended imm16. andi 0x0C→0100, ori 0x0D→0101, xori 0x0E→0110, all with zero-extended imm16. lui 0x0F→1000 with B=zero-extended imm16. For all I-type: A=rs, rd=instr[20:16].
- Any other opcode or funct: illegal=1, `wb_we`=0, Z and flags unchanged.
- `wb_we` = legal and `wb_rd`≠0. Writes to $0 are suppressed, but Z and the flags still update.

## Timing
- Reset values: `in_ready`=1, `wb_valid`=0, `wb_we`=0, `illegal`=0, `alu_op`=0000, `alu_a`=0, `alu_b`=0, `wb_rd`=0, Z=0, all flags 0, state IDLE.
- Latency: acceptance edge to `wb_valid` high is 3 cycles for a legal instruction and 2 for an illegal one.
- Minimum issue interval is 4 cycles with `wb_ready` tied high.
- `in_ready` is 0 in every state other than IDLE. There is no acceptance while WB is stalled.
- Operands are sampled only at acceptance. Later changes on `rs_data`/`rt_data` are ignored.
- `alu_*` outputs hold their values from DECODE until the next DECODE.
- Reset asserted mid-operation: immediate return to reset values. The in-flight instruction is dropped with no writeback.

## Structure
- Shared package `alu_pkg` holds:
  - the ALU op localparams (`ALU_ADDU`=0000 … `ALU_SLL`=1110);
  - the opcode and funct constants;
  - the FSM state enum.
- Natural sub-module: `alu_decode`. It is purely combinational, maps instr/rs/rt to op, A, B, rd and illegal, and is instantiated once.

## Test plan
- addu, rs=0xFFFFFFFF, rt=1, rd=3: `alu_op`=0000. `wb_valid` 3 cycles after acceptance with `wb_data`=0, `wb_rd`=3, `wb_we`=1, flag_z=1, flag_c=1.
- sra rd=5, rt=0x80000000, shamt=4: A=4, `alu_op`=1100. `wb_data` equals the ALU model output, and `flag_n` matches bit 31 of the result.
- addi rt=2, rs=10, imm=0xFFFF: B=0xFFFFFFFF, `wb_rd`=2, `wb_data`=9. Then ori with imm=0xFFFF: B=0x0000FFFF.
- Illegal opcode 0x3F: `wb_valid` 2 cycles after acceptance, `illegal`=1, `wb_we`=0, Z and flags unchanged.
- `wb_ready` low for 5 cycles: outputs hold stable, `in_ready`=0, and a pending `in_valid` is not accepted until the cycle after the WB handshake.
- `rst_n` pulsed low during EXEC: asynchronous return to all reset values, and no `wb_valid` follows. Write to rd=0: `wb_we`=0.

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_pkg : ALU op codes, MIPS opcode/funct constants, sequencer states |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package alu_pkg;

    localparam logic [3:0] ALU_ADDU = 4'b0000;
    localparam logic [3:0] ALU_SUBU = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0011;
    localparam logic [3:0] ALU_AND  = 4'b0100;
    localparam logic [3:0] ALU_OR   = 4'b0101;
    localparam logic [3:0] ALU_XOR  = 4'b0110;
    localparam logic [3:0] ALU_NOR  = 4'b0111;
    localparam logic [3:0] ALU_LUI  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1010;
    localparam logic [3:0] ALU_SLT  = 4'b1011;
    localparam logic [3:0] ALU_SRA  = 4'b1100;
    localparam logic [3:0] ALU_SRL  = 4'b1101;
    localparam logic [3:0] ALU_SLL  = 4'b1110;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECODE = 2'd1,
        ST_EXEC   = 2'd2,
        ST_WB     = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/alu_decode.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_decode : maps a MIPS instruction to ALU op, operands and rd       |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module alu_decode
    import alu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [31:0]       instr,
    input  logic [DATA_W-1:0] rs_data,
    input  logic [DATA_W-1:0] rt_data,
    output logic [3:0]        op,
    output logic [DATA_W-1:0] a,
    output logic [DATA_W-1:0] b,
    output logic [4:0]        rd,
    output logic              illegal
);

    logic [5:0]        opcode;
    logic [5:0]        funct;
    logic [DATA_W-1:0] imm_sext;
    logic [DATA_W-1:0] imm_zext;
    logic [DATA_W-1:0] shamt_zext;
    logic              unused_rs_field;

    assign opcode          = instr[31:26];
    assign funct           = instr[5:0];
    assign imm_sext        = {{(DATA_W-16){instr[15]}}, instr[15:0]};
    assign imm_zext        = {{(DATA_W-16){1'b0}}, instr[15:0]};
    assign shamt_zext      = {{(DATA_W-5){1'b0}}, instr[10:6]};
    // rs arrives already read from the register file
    assign unused_rs_field = ^instr[25:21];

    always_comb begin
        op      = ALU_ADDU;
        a       = rs_data;
        b       = rt_data;
        rd      = instr[15:11];
        illegal = 1'b0;
        if (opcode == OP_RTYPE) begin
            case (funct)
                FN_ADD:  op = ALU_ADD;
                FN_ADDU: op = ALU_ADDU;
                FN_SUB:  op = ALU_SUB;
                FN_SUBU: op = ALU_SUBU;
                FN_AND:  op = ALU_AND;
                FN_OR:   op = ALU_OR;
                FN_XOR:  op = ALU_XOR;
                FN_NOR:  op = ALU_NOR;
                FN_SLT:  op = ALU_SLT;
                FN_SLTU: op = ALU_SLTU;
                FN_SLL: begin op = ALU_SLL; a = shamt_zext; end
                FN_SRL: begin op = ALU_SRL; a = shamt_zext; end
                FN_SRA: begin op = ALU_SRA; a = shamt_zext; end
                default: illegal = 1'b1;
            endcase
        end else begin
            rd = instr[20:16];
            case (opcode)
                OP_ADDI:  begin op = ALU_ADD;  b = imm_sext; end
                OP_ADDIU: begin op = ALU_ADDU; b = imm_sext; end
                OP_SLTI:  begin op = ALU_SLT;  b = imm_sext; end
                OP_SLTIU: begin op = ALU_SLTU; b = imm_sext; end
                OP_ANDI:  begin op = ALU_AND;  b = imm_zext; end
                OP_ORI:   begin op = ALU_OR;   b = imm_zext; end
                OP_XORI:  begin op = ALU_XOR;  b = imm_zext; end
                OP_LUI:   begin op = ALU_LUI;  b = imm_zext; end
                default:  illegal = 1'b1;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_issue_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_issue_ctrl : accept/decode/execute/writeback sequencer for ALU    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       instr,
    input  logic [DATA_W-1:0] rs_data,
    input  logic [DATA_W-1:0] rt_data,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [3:0]        alu_op,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    input  logic              alu_carry,
    input  logic              alu_negative,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [4:0]        wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic              wb_we,
    output logic              illegal,
    output logic              flag_z,
    output logic              flag_c,
    output logic              flag_n
);

    state_t            state;
    state_t            state_nxt;
    logic [31:0]       instr_q;
    logic [DATA_W-1:0] rs_q;
    logic [DATA_W-1:0] rt_q;
    logic [DATA_W-1:0] z_q;
    logic [3:0]        dec_op;
    logic [DATA_W-1:0] dec_a;
    logic [DATA_W-1:0] dec_b;
    logic [4:0]        dec_rd;
    logic              dec_illegal;

    alu_decode #(.DATA_W(DATA_W)) u_decode (
        .instr   (instr_q),
        .rs_data (rs_q),
        .rt_data (rt_q),
        .op      (dec_op),
        .a       (dec_a),
        .b       (dec_b),
        .rd      (dec_rd),
        .illegal (dec_illegal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (in_valid) state_nxt = ST_DECODE;
            ST_DECODE: state_nxt = dec_illegal ? ST_WB : ST_EXEC;
            ST_EXEC:   state_nxt = ST_WB;
            ST_WB:     if (wb_ready) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state == ST_IDLE);
        wb_valid = (state == ST_WB);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q <= '0;
            rs_q    <= '0;
            rt_q    <= '0;
            alu_op  <= ALU_ADDU;
            alu_a   <= '0;
            alu_b   <= '0;
            wb_rd   <= '0;
            wb_we   <= 1'b0;
            illegal <= 1'b0;
            z_q     <= '0;
            flag_z  <= 1'b0;
            flag_c  <= 1'b0;
            flag_n  <= 1'b0;
        end else begin
            // operands are sampled only on the accepting edge
            if (state == ST_IDLE && in_valid) begin
                instr_q <= instr;
                rs_q    <= rs_data;
                rt_q    <= rt_data;
            end
            if (state == ST_DECODE) begin
                alu_op  <= dec_op;
                alu_a   <= dec_a;
                alu_b   <= dec_b;
                wb_rd   <= dec_rd;
                illegal <= dec_illegal;
                wb_we   <= !dec_illegal && (dec_rd != 5'd0);
            end
            if (state == ST_EXEC) begin
                z_q    <= alu_result;
                flag_z <= alu_zero;
                flag_c <= alu_carry;
                flag_n <= alu_negative;
            end
        end
    end

    assign wb_data = z_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_alu_issue_ctrl : directed bench with a behavioural ALU alongside   |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_alu_issue_ctrl;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_op;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic        alu_carry;
    logic        alu_negative;
    logic        wb_valid;
    logic        wb_ready;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_we;
    logic        illegal;
    logic        flag_z;
    logic        flag_c;
    logic        flag_n;

    int n_cmp;
    int n_err;

    alu_issue_ctrl #(.DATA_W(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .instr        (instr),
        .rs_data      (rs_data),
        .rt_data      (rt_data),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_op       (alu_op),
        .alu_result   (alu_result),
        .alu_zero     (alu_zero),
        .alu_carry    (alu_carry),
        .alu_negative (alu_negative),
        .wb_valid     (wb_valid),
        .wb_ready     (wb_ready),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .wb_we        (wb_we),
        .illegal      (illegal),
        .flag_z       (flag_z),
        .flag_c       (flag_c),
        .flag_n       (flag_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural datapath ALU; carry is the unsigned carry-out / no-borrow
    logic [32:0] sum33;
    always_comb begin
        sum33      = '0;
        alu_result = '0;
        alu_carry  = 1'b0;
        case (alu_op)
            4'b0000, 4'b0010: begin
                sum33      = {1'b0, alu_a} + {1'b0, alu_b};
                alu_result = sum33[31:0];
                alu_carry  = sum33[32];
            end
            4'b0001, 4'b0011: begin
                sum33      = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
                alu_result = sum33[31:0];
                alu_carry  = sum33[32];
            end
            4'b0100: alu_result = alu_a & alu_b;
            4'b0101: alu_result = alu_a | alu_b;
            4'b0110: alu_result = alu_a ^ alu_b;
            4'b0111: alu_result = ~(alu_a | alu_b);
            4'b1000: alu_result = alu_b << 16;
            4'b1010: alu_result = {31'd0, alu_a < alu_b};
            4'b1011: alu_result = {31'd0, $signed(alu_a) < $signed(alu_b)};
            4'b1100: alu_result = $unsigned($signed(alu_b) >>> alu_a[4:0]);
            4'b1101: alu_result = alu_b >> alu_a[4:0];
            4'b1110: alu_result = alu_b << alu_a[4:0];
            default: alu_result = '0;
        endcase
        alu_zero     = (alu_result == 32'd0);
        alu_negative = alu_result[31];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for in_ready, presents one instruction for the accepting
    // edge, then scrambles the operand inputs.
    task automatic issue(input logic [31:0] i, input logic [31:0] rs, input logic [31:0] rt);
        int waited;
        waited = 0;
        while (!in_ready && waited < 8) begin
            tick();
            waited++;
        end
        if (!in_ready) check("in_ready_wait", {31'd0, in_ready}, 32'd1);
        instr    = i;
        rs_data  = rs;
        rt_data  = rt;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        rs_data  = 32'hDEADBEEF;
        rt_data  = 32'hDEADBEEF;
    endtask

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        instr    = '0;
        rs_data  = '0;
        rt_data  = '0;
        wb_ready = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        check("rst_wb_we",    {31'd0, wb_we}, 32'd0);
        check("rst_illegal",  {31'd0, illegal}, 32'd0);
        check("rst_alu_op",   {28'd0, alu_op}, 32'd0);
        check("rst_alu_a",    alu_a, 32'd0);
        check("rst_alu_b",    alu_b, 32'd0);
        check("rst_wb_rd",    {27'd0, wb_rd}, 32'd0);
        check("rst_z",        wb_data, 32'd0);
        check("rst_flags",    {29'd0, flag_z, flag_c, flag_n}, 32'd0);

        // addu $3, rs=FFFFFFFF, rt=1
        issue(32'h00221821, 32'hFFFFFFFF, 32'h00000001);
        check("addu_in_ready_busy", {31'd0, in_ready}, 32'd0);
        tick();
        check("addu_op", {28'd0, alu_op}, 32'h0);
        check("addu_a",  alu_a, 32'hFFFFFFFF);
        check("addu_b",  alu_b, 32'h00000001);
        check("addu_wbv_early", {31'd0, wb_valid}, 32'd0);
        tick();
        check("addu_wbv",   {31'd0, wb_valid}, 32'd1);
        check("addu_data",  wb_data, 32'h0);
        check("addu_rd",    {27'd0, wb_rd}, 32'd3);
        check("addu_we",    {31'd0, wb_we}, 32'd1);
        check("addu_flags", {29'd0, flag_z, flag_c, flag_n}, 32'b110);
        tick();

        // sra $5, rt=80000000, shamt 4
        issue(32'h00062903, 32'h00000000, 32'h80000000);
        tick();
        check("sra_op", {28'd0, alu_op}, 32'hC);
        check("sra_a",  alu_a, 32'd4);
        tick();
        check("sra_data",  wb_data, 32'hF8000000);
        check("sra_rd",    {27'd0, wb_rd}, 32'd5);
        check("sra_flags", {29'd0, flag_z, flag_c, flag_n}, 32'b001);
        tick();

        // addi $2, rs=10, imm=FFFF
        issue(32'h2082FFFF, 32'd10, 32'h0);
        tick();
        check("addi_b",  alu_b, 32'hFFFFFFFF);
        tick();
        check("addi_data",  wb_data, 32'd9);
        check("addi_rd",    {27'd0, wb_rd}, 32'd2);
        check("addi_flags", {29'd0, flag_z, flag_c, flag_n}, 32'b010);
        tick();

        // ori $7, rs=12340000, imm=FFFF
        issue(32'h3487FFFF, 32'h12340000, 32'h0);
        tick();
        check("ori_op", {28'd0, alu_op}, 32'h5);
        check("ori_b",  alu_b, 32'h0000FFFF);
        tick();
        check("ori_data", wb_data, 32'h1234FFFF);
        check("ori_rd",   {27'd0, wb_rd}, 32'd7);
        tick();

        // illegal opcode 0x3F
        issue(32'hFC000000, 32'h11111111, 32'h22222222);
        tick();
        check("ill_wbv",   {31'd0, wb_valid}, 32'd1);
        check("ill_bit",   {31'd0, illegal}, 32'd1);
        check("ill_we",    {31'd0, wb_we}, 32'd0);
        check("ill_z",     wb_data, 32'h1234FFFF);
        check("ill_flags", {29'd0, flag_z, flag_c, flag_n}, 32'b000);
        tick();

        // sub $9, 5-7 with writeback stalled, and a pending and
        wb_ready = 1'b0;
        issue(32'h00224822, 32'd5, 32'd7);
        tick();
        tick();
        instr    = 32'h00222024;
        rs_data  = 32'h000000F0;
        rt_data  = 32'h0000003C;
        in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            check("stall_wbv",  {31'd0, wb_valid}, 32'd1);
            check("stall_rdy",  {31'd0, in_ready}, 32'd0);
            check("stall_data", wb_data, 32'hFFFFFFFE);
            check("stall_rd",   {27'd0, wb_rd}, 32'd9);
            tick();
        end
        check("sub_flags", {29'd0, flag_z, flag_c, flag_n}, 32'b001);
        wb_ready = 1'b1;
        tick();
        check("post_hs_rdy", {31'd0, in_ready}, 32'd1);
        check("post_hs_wbv", {31'd0, wb_valid}, 32'd0);
        check("post_hs_op",  {28'd0, alu_op}, 32'h3);
        tick();
        in_valid = 1'b0;
        check("pend_acc_rdy", {31'd0, in_ready}, 32'd0);
        tick();
        check("and_op", {28'd0, alu_op}, 32'h4);
        check("and_a",  alu_a, 32'h000000F0);
        tick();
        check("and_data", wb_data, 32'h00000030);
        check("and_rd",   {27'd0, wb_rd}, 32'd4);
        tick();

        // addu $0: result computed, write suppressed
        issue(32'h00220021, 32'd3, 32'd4);
        tick();
        tick();
        check("rd0_we",   {31'd0, wb_we}, 32'd0);
        check("rd0_data", wb_data, 32'd7);
        tick();

        // reset pulsed while in EXEC
        issue(32'h00221820, 32'h0000000F, 32'h00000001);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_rdy",   {31'd0, in_ready}, 32'd1);
        check("arst_op",    {28'd0, alu_op}, 32'h0);
        check("arst_a",     alu_a, 32'd0);
        check("arst_z",     wb_data, 32'd0);
        check("arst_rd",    {27'd0, wb_rd}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("arst_no_wb", {31'd0, wb_valid}, 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
